trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Sequences trap entry and return around the write-back stage and the CSR file.
- Synchronous exceptions and xRET arrive from write-back.
- Machine interrupts (MEI/MSI/MTI) are qualified by mie/mstatus.MIE.
- For interrupts: stalls the front end, drains the pipeline, then pulses the interrupt-take strobe to the CSR file.
- For every trap or xRET: issues the flush and PC redirect to fetch.

Parameters:
DRAIN_TIMEOUT, 64, drain cycles after which drain_timeout_o pulses (waiting continues).
CNT_W, 8, width of the drain counter; must satisfy 2^CNT_W > DRAIN_TIMEOUT.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
xint_meip_i  in  1  machine external interrupt pending
xint_mtip_i  in  1  machine timer interrupt pending
xint_msip_i  in  1  machine software interrupt pending
mie_i  in  32  mie CSR value
mstatus_mie_i  in  1  mstatus.MIE
exc_i  in  1  write-back took exception or xRET this cycle
exc_ret_addr_i  in  32  redirect target from CSR (mtvec or mepc), valid with exc_i or in TAKE
pipe_empty_i  in  1  no valid instruction in EX/MEM/WB
mem_busy_i  in  1  data-memory transaction outstanding
next_pc_i  in  32  PC of oldest unretired instruction (mepc for interrupts)
stall_o  out  1  freeze IF/ID
flush_o  out  1  kill IF..MEM contents
pc_redirect_o  out  1  load pc_target_o into fetch PC
pc_target_o  out  32  redirect address
int_take_o  out  1  one-cycle strobe: CSR records interrupt trap
int_cause_o  out  32  mcause for interrupt
int_epc_o  out  32  mepc for interrupt
drain_timeout_o  out  1  one-cycle pulse at DRAIN_TIMEOUT
busy_o  out  1  state != IDLE

Behaviour:
- Clocking: single clock clk_i; rst_i synchronous, active-high.
- Reset: state=IDLE; counter=0; target=0; every output 0.
- Reset mid-operation abandons any trap sequence; no flush or strobe is issued afterwards.
- Interrupt pending: pend = mstatus_mie_i & |(irq & {mie_i[11], mie_i[3], mie_i[7]}).
- Interrupt priority: MEI > MSI > MTI. Causes are 0x8000000B, 0x80000003, 0x80000007.
- FSM states: IDLE, DRAIN, TAKE, FLUSH.
- IDLE:
  - exc_i=1 -> latch exc_ret_addr_i, go to FLUSH. Exception beats a simultaneous pend.
  - else pend=1 -> go to DRAIN, counter=0.
- DRAIN:
  - stall_o=1; counter increments, saturating; drain_timeout_o=1 in the cycle counter==DRAIN_TIMEOUT-1.
  - exc_i=1 (older instruction faulted) -> latch target, go to FLUSH. Interrupt stays pending and is retaken from IDLE.
  - pend=0 (interrupt withdrawn) -> go to IDLE; stall releases next cycle.
  - pipe_empty_i & !mem_busy_i -> go to TAKE; latch cause (priority-encoded that cycle) and next_pc_i.
- TAKE:
  - stall_o=1; int_take_o = !exc_i; int_cause_o and int_epc_o are driven from the latches.
  - Latch exc_ret_addr_i (mtvec returned combinationally by CSR), go to FLUSH.
  - exc_i=1 in TAKE: int_take_o suppressed, exception target latched instead.
- FLUSH: stall_o=1, flush_o=1, pc_redirect_o=1, pc_target_o=latched target for exactly one cycle; then go to IDLE.
- int_cause_o and int_epc_o are 0 outside TAKE.
- pc_target_o is 0 outside FLUSH.
- Latency, irq to redirect, with pipe empty: pend at cycle N -> DRAIN N+1 -> TAKE N+2 -> FLUSH N+3 -> IDLE N+4.
- Latency, exc_i to redirect: exc_i at cycle M -> FLUSH M+1.
- Back-to-back: exc_i in FLUSH is ignored; write-back holds no valid instruction after the flush.

Optional Feature:
TRAP_IRQ_SYNC_EN:
- Defined: each xint_* passes through a 2-flop synchronizer (reset to 0) before use. Irq-to-redirect latency becomes 6 cycles.
- Undefined: inputs are used directly; latency 4 cycles.

Decomposition:
- Package trap_pkg: FSM state encoding; constants CAUSE_MEI=0x8000000B, CAUSE_MSI=0x80000003, CAUSE_MTI=0x80000007; mie bit indices 11/3/7.
- Sub-module irq_sync: 2-flop synchronizer, 3 bits wide, synchronous reset. Instantiated only under TRAP_IRQ_SYNC_EN.

Test Plan:
1. exc_i=1 in IDLE with exc_ret_addr_i=0x00000100 -> next cycle flush_o=1, pc_redirect_o=1, pc_target_o=0x100 for one cycle; busy_o=0 after.
2. mstatus_mie_i=1, mie_i=0x888, meip=mtip=1, pipe empty, next_pc_i=0x2000, exc_ret_addr_i=0x80 -> int_take_o at N+2 with cause 0x8000000B, epc 0x2000; redirect to 0x80 at N+3.
3. mtip=1, mie_i[7]=1, mem_busy_i held high 70 cycles -> stall_o held; drain_timeout_o pulses once at the 64th DRAIN cycle; TAKE follows when mem_busy_i falls.
4. Interrupt pending in DRAIN, then exc_i=1 with target 0x40 -> no int_take_o; flush/redirect to 0x40; TAKE reached after returning to IDLE while irq still asserted.
5. mstatus_mie_i=0 with all irqs and mie set -> stays IDLE, stall_o=0 indefinitely.
6. rst_i asserted during TAKE -> next cycle every output 0, state IDLE, no flush issued.

Source files
------------

// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_pkg
// Brief    : FSM encoding, interrupt cause codes and mie bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package trap_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TAKE  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  localparam int MIE_MEI_BIT = 11;
  localparam int MIE_MSI_BIT = 3;
  localparam int MIE_MTI_BIT = 7;

  typedef struct packed {
    logic mei;
    logic msi;
    logic mti;
  } irq_vec_t;

  // Priority MEI > MSI > MTI over the already-enabled interrupt set.
  function automatic logic [31:0] irq_cause(input irq_vec_t act);
    logic [31:0] cause;
    cause = '0;
    if (act.mei)      cause = CAUSE_MEI;
    else if (act.msi) cause = CAUSE_MSI;
    else if (act.mti) cause = CAUSE_MTI;
    return cause;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_if
// Brief    : Pipeline/CSR-facing signal bundle of trap_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if;
  logic        xint_meip_i;
  logic        xint_mtip_i;
  logic        xint_msip_i;
  logic [31:0] mie_i;
  logic        mstatus_mie_i;
  logic        exc_i;
  logic [31:0] exc_ret_addr_i;
  logic        pipe_empty_i;
  logic        mem_busy_i;
  logic [31:0] next_pc_i;
  logic        stall_o;
  logic        flush_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        int_take_o;
  logic [31:0] int_cause_o;
  logic [31:0] int_epc_o;
  logic        drain_timeout_o;
  logic        busy_o;

  modport slave (
    input  xint_meip_i, xint_mtip_i, xint_msip_i, mie_i, mstatus_mie_i,
           exc_i, exc_ret_addr_i, pipe_empty_i, mem_busy_i, next_pc_i,
    output stall_o, flush_o, pc_redirect_o, pc_target_o, int_take_o,
           int_cause_o, int_epc_o, drain_timeout_o, busy_o
  );

  modport master (
    output xint_meip_i, xint_mtip_i, xint_msip_i, mie_i, mstatus_mie_i,
           exc_i, exc_ret_addr_i, pipe_empty_i, mem_busy_i, next_pc_i,
    input  stall_o, flush_o, pc_redirect_o, pc_target_o, int_take_o,
           int_cause_o, int_epc_o, drain_timeout_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync
// Brief    : 3-bit two-flop synchronizer for the machine interrupt lines.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  output logic [2:0] dout
);
  logic [2:0] r_meta;
  logic [2:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
    end
  end

  assign dout = r_sync;
endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Brief    : Sequences trap entry/return (exceptions, xRET, M-mode irqs).
//            Macro TRAP_IRQ_SYNC_EN adds a 2-flop synchronizer on xint_*.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  trap_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DRAIN_TIMEOUT - 1);

  logic [2:0]       w_irq_raw;
  logic [2:0]       w_irq;
  irq_vec_t         w_act;
  logic             w_pend;
  logic             w_drained;
  logic             w_unused_mie;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_target;
  logic [31:0]      r_cause;
  logic [31:0]      r_epc;

  assign w_irq_raw = {bus.xint_meip_i, bus.xint_msip_i, bus.xint_mtip_i};

`ifdef TRAP_IRQ_SYNC_EN
  irq_sync u_irq_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (w_irq_raw),
    .dout (w_irq)
  );
`else
  assign w_irq = w_irq_raw;
`endif

  assign w_act = irq_vec_t'(w_irq & {bus.mie_i[MIE_MEI_BIT],
                                     bus.mie_i[MIE_MSI_BIT],
                                     bus.mie_i[MIE_MTI_BIT]});
  assign w_pend    = bus.mstatus_mie_i & (|w_act);
  assign w_drained = bus.pipe_empty_i & ~bus.mem_busy_i;

  assign w_unused_mie = ^{bus.mie_i[31:12], bus.mie_i[10:8],
                          bus.mie_i[6:4], bus.mie_i[2:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_cause  <= '0;
      r_epc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.exc_i) begin
            r_target <= bus.exc_ret_addr_i;
            r_state  <= ST_FLUSH;
          end else if (w_pend) begin
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          // An older faulting instruction wins; the irq is re-evaluated from IDLE.
          if (bus.exc_i) begin
            r_target <= bus.exc_ret_addr_i;
            r_state  <= ST_FLUSH;
          end else if (!w_pend) begin
            r_state <= ST_IDLE;
          end else if (w_drained) begin
            r_cause <= irq_cause(w_act);
            r_epc   <= bus.next_pc_i;
            r_state <= ST_TAKE;
          end
        end
        ST_TAKE: begin
          r_target <= bus.exc_ret_addr_i;
          r_state  <= ST_FLUSH;
        end
        ST_FLUSH: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o          = (r_state != ST_IDLE);
  assign bus.stall_o         = (r_state != ST_IDLE);
  assign bus.flush_o         = (r_state == ST_FLUSH);
  assign bus.pc_redirect_o   = (r_state == ST_FLUSH);
  assign bus.pc_target_o     = (r_state == ST_FLUSH) ? r_target : '0;
  assign bus.int_take_o      = (r_state == ST_TAKE) & ~bus.exc_i;
  assign bus.int_cause_o     = (r_state == ST_TAKE) ? r_cause : '0;
  assign bus.int_epc_o       = (r_state == ST_TAKE) ? r_epc : '0;
  assign bus.drain_timeout_o = (r_state == ST_DRAIN) && (r_cnt == c_drain_last);
endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Scoreboard bench for trap_ctrl with a timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;
  localparam int DT = 64;
`ifdef TRAP_IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int PH_I = 0;
  localparam int PH_D = 1;
  localparam int PH_T = 2;
  localparam int PH_F = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [101:0] exp_q[$];
  string        name_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trap_ctrl_if bus ();
  trap_ctrl #(.DRAIN_TIMEOUT(DT), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Output vector: busy, stall, flush, redirect, target, take, cause, epc, timeout.
  always @(negedge clk) begin : mon
    logic [101:0] a;
    logic [101:0] e;
    string        n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {bus.busy_o, bus.stall_o, bus.flush_o, bus.pc_redirect_o, bus.pc_target_o,
           bus.int_take_o, bus.int_cause_o, bus.int_epc_o, bus.drain_timeout_o};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cyc%0d %s: got %h want %h", cyc, n, a, e);
      end
    end
  end

  function automatic bit ref_pend(input logic [2:0] irq, input logic [31:0] mie);
    return (irq[2] && mie[11]) || (irq[1] && mie[3]) || (irq[0] && mie[7]);
  endfunction

  function automatic logic [31:0] ref_cause(input logic [2:0] irq, input logic [31:0] mie);
    if (irq[2] && mie[11]) return 32'h8000000B;
    if (irq[1] && mie[3])  return 32'h80000003;
    if (irq[0] && mie[7])  return 32'h80000007;
    return 32'h0;
  endfunction

  task automatic expect_cycle(input int ph, input logic [31:0] tgt, input logic take,
                              input logic [31:0] cause, input logic [31:0] epc,
                              input logic to, input string n);
    logic [101:0] v;
    case (ph)
      PH_I:    v = '0;
      PH_D:    v = {4'b1100, 32'h0, 1'b0, 64'h0, to};
      PH_T:    v = {4'b1100, 32'h0, take, cause, epc, 1'b0};
      default: v = {4'b1111, tgt, 1'b0, 64'h0, 1'b0};
    endcase
    exp_q.push_back(v);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string n);
    expect_cycle(PH_I, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, n);
  endtask

  task automatic drain(input int k, input string n);
    expect_cycle(PH_D, 32'h0, 1'b0, 32'h0, 32'h0, (k == DT - 1), n);
  endtask

  task automatic noise(input bit fix, input logic [31:0] fpc, input logic [31:0] ftgt);
    bus.next_pc_i      = fix ? fpc : $urandom;
    bus.exc_ret_addr_i = fix ? ftgt : $urandom;
  endtask

  task automatic not_ready();
    bus.pipe_empty_i = 1'($urandom_range(0, 1));
    bus.mem_busy_i   = 1'($urandom_range(0, 1));
    if (bus.pipe_empty_i) bus.mem_busy_i = 1'b1;
  endtask

  task automatic set_irq(input logic [2:0] irq);
    bus.xint_meip_i = irq[2];
    bus.xint_msip_i = irq[1];
    bus.xint_mtip_i = irq[0];
  endtask

  task automatic scn_exc(input logic [31:0] addr, input bit junk_in_flush);
    noise(1'b0, 0, 0);
    bus.exc_i = 1'b1;
    bus.exc_ret_addr_i = addr;
    idle("exc_issue");
    noise(1'b0, 0, 0);
    bus.exc_i = junk_in_flush;
    expect_cycle(PH_F, addr, 1'b0, 32'h0, 32'h0, 1'b0, "exc_flush");
    noise(1'b0, 0, 0);
    bus.exc_i = 1'b0;
    idle("exc_after");
  endtask

  task automatic scn_irq(input logic [2:0] irq, input logic [31:0] mie, input int d,
                         input int exc_at_in, input bit exc_take, input int wd_at,
                         input bit rst_take, input bit fix,
                         input logic [31:0] fpc, input logic [31:0] ftgt);
    logic [31:0] cause, epc, tgt;
    int k, exc_at;
    bit done;
    exc_at = exc_at_in;
    cause  = ref_cause(irq, mie);
    bus.mie_i = mie;
    bus.mstatus_mie_i = 1'b1;
    bus.pipe_empty_i = 1'b0;
    bus.mem_busy_i = 1'b0;
    bus.exc_i = 1'b0;
    set_irq(irq);
    for (int i = 0; i <= SL; i++) begin
      noise(fix, fpc, ftgt);
      idle("irq_pend");
    end
    if (!ref_pend(irq, mie)) begin
      for (int i = 0; i < 4; i++) begin
        noise(fix, fpc, ftgt);
        idle("irq_masked");
      end
    end else begin
      k = 0;
      done = 1'b0;
      while (!done) begin
        noise(fix, fpc, ftgt);
        bus.exc_i = 1'b0;
        if (k == exc_at) begin
          bus.pipe_empty_i = 1'($urandom_range(0, 1));
          bus.mem_busy_i   = 1'($urandom_range(0, 1));
          bus.exc_i = 1'b1;
          tgt = bus.exc_ret_addr_i;
          drain(k, "drain_exc");
          noise(fix, fpc, ftgt);
          bus.exc_i = 1'b0;
          bus.pipe_empty_i = 1'b0;
          expect_cycle(PH_F, tgt, 1'b0, 32'h0, 32'h0, 1'b0, "drain_exc_flush");
          noise(fix, fpc, ftgt);
          idle("retake_idle");
          k = 0;
          exc_at = -1;
          continue;
        end else if (k == wd_at) begin
          not_ready();
          bus.mstatus_mie_i = 1'b0;
          drain(k, "drain_withdraw");
          set_irq(3'b000);
          noise(fix, fpc, ftgt);
          idle("withdrawn");
          done = 1'b1;
        end else if (k == d) begin
          bus.pipe_empty_i = 1'b1;
          bus.mem_busy_i = 1'b0;
          epc = bus.next_pc_i;
          drain(k, "drain_ready");
          noise(fix, fpc, ftgt);
          bus.exc_i = exc_take;
          tgt = bus.exc_ret_addr_i;
          bus.mstatus_mie_i = 1'b0;
          set_irq(3'b000);
          rst = rst_take;
          expect_cycle(PH_T, 32'h0, !exc_take, cause, epc, 1'b0, "take");
          noise(fix, fpc, ftgt);
          bus.exc_i = 1'b0;
          rst = 1'b0;
          if (rst_take) idle("after_rst");
          else expect_cycle(PH_F, tgt, 1'b0, 32'h0, 32'h0, 1'b0, "take_flush");
          noise(fix, fpc, ftgt);
          idle("after_take");
          done = 1'b1;
        end else begin
          not_ready();
          drain(k, "drain_wait");
        end
        k++;
      end
    end
    bus.mstatus_mie_i = 1'b0;
    set_irq(3'b000);
    bus.pipe_empty_i = 1'b0;
    bus.mem_busy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      noise(1'b0, 0, 0);
      idle("gap");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of stimulus want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, d;
    set_irq(3'b000);
    bus.mie_i = '0;
    bus.mstatus_mie_i = 1'b0;
    bus.exc_i = 1'b0;
    bus.exc_ret_addr_i = '0;
    bus.pipe_empty_i = 1'b0;
    bus.mem_busy_i = 1'b0;
    bus.next_pc_i = '0;
    @(posedge clk);
    #1;
    idle("reset");
    idle("reset");
    rst = 1'b0;
    idle("post_reset");

    scn_exc(32'h0000_0100, 1'b0);
    scn_irq(3'b101, 32'h888, 0, -1, 1'b0, -1, 1'b0, 1'b1, 32'h2000, 32'h80);
    scn_irq(3'b001, 32'h080, 70, -1, 1'b0, -1, 1'b0, 1'b0, 0, 0);
    scn_irq(3'b001, 32'h080, 5, 2, 1'b0, -1, 1'b0, 1'b1, 32'h3000, 32'h40);
    bus.mstatus_mie_i = 1'b0;
    bus.mie_i = '1;
    set_irq(3'b111);
    for (int i = 0; i < 20; i++) begin
      noise(1'b0, 0, 0);
      idle("mie_off");
    end
    set_irq(3'b000);
    scn_irq(3'b010, 32'h008, 1, -1, 1'b0, -1, 1'b1, 1'b0, 0, 0);
    scn_exc($urandom, 1'b1);

    for (int s = 0; s < 60; s++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: scn_exc($urandom, 1'($urandom_range(0, 1)));
        1: scn_irq(3'($urandom_range(1, 7)), $urandom, $urandom_range(0, 6), -1,
                   ($urandom_range(0, 3) == 0), -1, ($urandom_range(0, 9) == 0),
                   1'b0, 0, 0);
        2: begin
          d = $urandom_range(2, 8);
          scn_irq(3'($urandom_range(1, 7)), $urandom, d, $urandom_range(0, d - 1),
                  1'b0, -1, 1'b0, 1'b0, 0, 0);
        end
        default: begin
          d = $urandom_range(3, 8);
          scn_irq(3'($urandom_range(1, 7)), $urandom, d, -1, 1'b0,
                  $urandom_range(0, d - 1), 1'b0, 1'b0, 0, 0);
        end
      endcase
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
